// File: rtl/calc_pkg.sv
// Shared definitions for the calc_stack accumulator: op encodings and the op type.
package calc_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_AND = 3'b000;
   localparam op_t OP_OR  = 3'b001;
   localparam op_t OP_ADD = 3'b010;
   localparam op_t OP_SUB = 3'b011;
   localparam op_t OP_SLT = 3'b100;
   localparam op_t OP_SLL = 3'b101;
   localparam op_t OP_SRA = 3'b110;
   localparam op_t OP_XOR = 3'b111;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU for calc_stack. Define CALC_STACK_SAT_EN to make ADD/SUB
// saturate to the signed limits instead of wrapping.
module calc_alu
   import calc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   sh;
   logic             sum_ovf;
   logic             diff_ovf;

   always_comb begin
      sh       = b[SHW-1:0];
      sum      = a + b;
      diff     = a - b;
      sum_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      diff_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      result   = '0;
      ovf      = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_ADD: begin
            result = sum;
            ovf    = sum_ovf;
         end
         OP_SUB: begin
            result = diff;
            ovf    = diff_ovf;
         end
         OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL: result = a << sh;
         OP_SRA: result = $signed(a) >>> sh;
         default: result = a ^ b;
      endcase
`ifdef CALC_STACK_SAT_EN
      // On overflow the true result lies beyond the limit on the side of a's sign.
      if (ovf) begin
         result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

endmodule

// File: rtl/calc_stack.sv
// Accumulator with edge-triggered apply/undo and a circular undo history.
// Optional saturation via CALC_STACK_SAT_EN lives in calc_alu.
module calc_stack
   import calc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [2:0]                 op,
   input  logic [WIDTH-1:0]           operand,
   input  logic                       apply,
   input  logic                       undo,
   input  logic                       clear,
   output logic [WIDTH-1:0]           acc,
   output logic                       zero,
   output logic                       ovf,
   output logic [$clog2(DEPTH+1)-1:0] hist_cnt,
   output logic                       undo_err
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             undo_err_q, undo_err_d;
   logic             apply_q, apply_d;
   logic             undo_q, undo_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] hist_q [DEPTH];
   logic [WIDTH-1:0] hist_d [DEPTH];

   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr_inc;
   logic             apply_fire;
   logic             undo_fire;
   logic [WIDTH-1:0] alu_result;
   logic             alu_ovf;

   calc_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (acc_q),
      .b      (operand),
      .op     (op_t'(op)),
      .result (alu_result),
      .ovf    (alu_ovf)
   );

   // apply/undo are level requests: a request is taken only on the cycle the
   // input is 1 while its registered copy is 0, so holding it high acts once.
   assign apply_fire = apply & ~apply_q;
   assign undo_fire  = undo & ~undo_q;

   assign rd_ptr     = (wr_ptr_q == '0) ? PTR_LAST : wr_ptr_q - PW'(1);
   assign wr_ptr_inc = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);

   always_comb begin
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      undo_err_d = 1'b0;
      apply_d    = apply;
      undo_d     = undo;
      hist_d     = hist_q;
      if (clear) begin
         acc_d    = '0;
         ovf_d    = 1'b0;
         cnt_d    = '0;
         wr_ptr_d = '0;
      end else if (apply_fire) begin
         // When full, wr_ptr already points at the oldest entry.
         hist_d[wr_ptr_q] = acc_q;
         wr_ptr_d         = wr_ptr_inc;
         if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
         acc_d = alu_result;
         ovf_d = alu_ovf;
      end else if (undo_fire) begin
         if (cnt_q != '0) begin
            acc_d    = hist_q[rd_ptr];
            wr_ptr_d = rd_ptr;
            cnt_d    = cnt_q - CW'(1);
         end else begin
            undo_err_d = 1'b1;
         end
      end
      zero_d = (acc_d == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q      <= '0;
         zero_q     <= 1'b1;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         undo_err_q <= 1'b0;
         apply_q    <= 1'b1;
         undo_q     <= 1'b1;
         wr_ptr_q   <= '0;
      end else begin
         acc_q      <= acc_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         undo_err_q <= undo_err_d;
         apply_q    <= apply_d;
         undo_q     <= undo_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // History contents need no reset: cnt_q alone decides which entries are valid.
   always_ff @(posedge clk) begin
      hist_q <= hist_d;
   end

   assign acc      = acc_q;
   assign zero     = zero_q;
   assign ovf      = ovf_q;
   assign hist_cnt = cnt_q;
   assign undo_err = undo_err_q;

endmodule

// File: doc/calc_stack.md
CALC_STACK -- requirements
Module: calc_stack

Interface
REQ-001 Parameter WIDTH, default 16: accumulator and operand width in bits, minimum 4.
REQ-002 Parameter DEPTH, default 4: undo-history entries, minimum 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 op  input  3  operation select: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 SLL, 110 SRA, 111 XOR.
REQ-006 operand  input  WIDTH  second ALU operand.
REQ-007 apply  input  1  level request; only its rising edge executes op.
REQ-008 undo  input  1  level request; only its rising edge restores the previous accumulator.
REQ-009 clear  input  1  synchronous clear, active-high.
REQ-010 acc  output  WIDTH  registered accumulator.
REQ-011 zero  output  1  registered; equals 1 when acc is all zeros.
REQ-012 ovf  output  1  registered signed-overflow flag from the last ADD/SUB.
REQ-013 hist_cnt  output  clog2(DEPTH+1)  number of valid history entries.
REQ-014 undo_err  output  1  one-cycle pulse on an undo attempted with an empty history.

Function
REQ-015 Edge detection: apply_q and undo_q are registered copies of apply and undo; a request fires on the cycle where the input is 1 and its _q copy is 0.
REQ-016 Holding apply or undo high for N cycles executes exactly one operation.
REQ-017 Apply fire: acc <= ALU(acc, operand, op) at that clock edge, giving latency 1 cycle from the sampled edge; the old acc is pushed onto the history.
REQ-018 ADD/SUB wrap modulo 2^WIDTH.
REQ-019 ovf is set on signed overflow of ADD/SUB, cleared by any other op, and held during undo.
REQ-020 SLT compares acc and operand as signed values; the result is 1 or 0, zero-extended.
REQ-021 SLL and SRA shift acc by operand[clog2(WIDTH)-1:0]; SRA replicates the MSB.
REQ-022 History full (hist_cnt==DEPTH) plus apply: the oldest entry is overwritten (circular) and hist_cnt stays at DEPTH.
REQ-023 Undo fire with hist_cnt>0: acc <= most recent entry, hist_cnt decrements, and zero is recomputed.
REQ-024 Undo fire with hist_cnt==0: acc is unchanged and undo_err=1 for exactly one cycle.
REQ-025 Apply and undo firing in the same cycle: apply executes and the undo edge is discarded.
REQ-026 clear has priority over apply and undo: acc=0, zero=1, ovf=0, hist_cnt=0; the edge registers still update.

Reset
REQ-027 rst_n=0 at a clock edge sets acc=0, zero=1, ovf=0, hist_cnt=0, undo_err=0, apply_q=1, undo_q=1; inputs already held high therefore do not fire after release.
REQ-028 Reset asserted mid-sequence discards all history, and no partial operation survives.

Configuration
REQ-029 Macro CALC_STACK_SAT_EN defined: ADD/SUB saturate to the signed maximum 2^(WIDTH-1)-1 or the signed minimum -2^(WIDTH-1), and ovf still flags the saturation event.
REQ-030 Macro CALC_STACK_SAT_EN undefined: ADD/SUB wrap per REQ-018, and no saturation logic is present.

Structure
REQ-031 Shared package calc_pkg SHALL hold the 3-bit op encodings as localparams and the op typedef.
REQ-032 Sub-module calc_alu SHALL be purely combinational, parametrised by WIDTH, and return result and ovf; calc_stack SHALL hold all state and the history buffer (register array, write pointer, count).

Verification
REQ-033 WIDTH=16 sequence: reset; ADD 354a -> acc=354a; SUB 1234 -> 2316; OR 1001 -> 3317; AND f0f0 -> 3010; XOR 1fa2 -> 2fb2; each update appears 1 cycle after the apply edge.
REQ-034 acc=7fff, ADD 0001 -> acc=8000 and ovf=1 without CALC_STACK_SAT_EN; acc=7fff and ovf=1 with it.
REQ-035 acc=8000, SRA 1 -> c000; SLL 4 from 0012 -> 0120; SLT 46ff with acc=ffff -> 0001.
REQ-036 DEPTH=4: five applies then five undos -> four undos restore values 2..5 back in order, and the fifth leaves acc unchanged with undo_err pulsing for 1 cycle.
REQ-037 apply held high for 10 cycles -> one operation; apply and undo rising together -> apply executes and hist_cnt increments.
REQ-038 clear asserted together with an apply edge -> acc=0, hist_cnt=0; rst_n low mid-sequence -> all outputs at reset values on the next edge.
